bw_io_bs_capshift_3x: RTL and testbench
=======================================

Name: bw_io_bs_capshift_3x

Overview:
Boundary-scan capture/shift segment that produces the data the boundary-scan update-latch stage holds.
- Captures pad-side values in parallel, shifts them serially between tdi and tdo, then issues a one-cycle update strobe together with the parallel shift contents.
- Sits in the IO boundary-scan chain, between the JTAG DR sequencing signals and the per-pad update stage.

Parameters:
WIDTH, 3, number of boundary-scan cells in the segment; must be at least 1.
CNT_W, $clog2(WIDTH+1), width of the shift counter. It is derived from WIDTH and is not overridden.

Ports:
clk  input  1  single clock for all state.
rst_l  input  1  reset; synchronous, active-low.
capture_dr  input  1  DR capture request from the TAP sequencer.
shift_dr  input  1  DR shift request, one bit per cycle.
update_dr  input  1  DR update request.
tdi  input  1  serial scan in.
pad_in  input  WIDTH  pad-side values to capture.
tdo  output  1  serial scan out; equal to sr[0].
sd  output  WIDTH  parallel shift-register contents; feeds the update stage d inputs.
up_dr  output  1  one-cycle update strobe to the update stage.
frame_ok  output  1  valid only while up_dr=1; high when exactly WIDTH shifts occurred since the last capture.
busy  output  1  high when the state is not IDLE.

Behaviour:
Reset (rst_l=0 at a clk edge):
- state=IDLE, sr=0, cnt=0.
- Outputs: tdo=0, sd=0, up_dr=0, frame_ok=0, busy=0.
- Reset wins over all requests. A reset mid-shift discards partial data and does not produce up_dr.

States: IDLE, CAP, SHIFT, UPD.

Request priority when several requests are high in the same cycle: capture_dr > shift_dr > update_dr.

IDLE:
- capture_dr -> CAP.
- shift_dr -> SHIFT, and the shift is performed in the same cycle.
- update_dr -> UPD.

CAP (one cycle):
- sr <= pad_in, cnt <= 0.
- Next state: SHIFT if shift_dr, else UPD if update_dr, else IDLE.

SHIFT:
- Each cycle with shift_dr=1: sr <= {tdi, sr[WIDTH-1:1]}, cnt <= cnt+1.
- cnt saturates at WIDTH+1, meaning an overshift was seen.
- With shift_dr=0: capture_dr -> CAP, update_dr -> UPD, otherwise IDLE (pause). sr and cnt are held during the pause.

UPD (one cycle):
- up_dr=1, sd stable, frame_ok=(cnt==WIDTH).
- Then cnt <= 0 and state -> IDLE.
- A capture_dr arriving during UPD is taken next cycle from IDLE.

Outputs and timing:
- up_dr is registered: high exactly in the UPD cycle and never two cycles in a row.
- sd is a registered copy of sr and changes only on capture or shift edges.
- tdo is sr[0]; the first captured bit appears on tdo the cycle after CAP.
- Latency: capture to tdo valid is 1 cycle; update_dr to up_dr is 1 cycle.

Boundary cases:
- Update with no preceding shift: frame_ok=0 and up_dr still pulses.
- Capture in the middle of a shift restarts the frame with cnt=0.
- WIDTH=1 is legal; sr then degenerates to a single flop.

Decomposition:
- Shared package bw_io_bs_pkg holds:
  - the state enum bs_dr_state_e {IDLE, CAP, SHIFT, UPD};
  - the default width constant BS_SEG_WIDTH=3;
  - a CNT_W helper function.
- Natural sub-module: bw_io_bs_cell, one capture/shift cell (mux of pad_in/serial-in plus flop), instantiated WIDTH times. The FSM and counter stay in the top-level module.

Test Plan:
1. Reset, then capture_dr with pad_in=3'b101 -> next cycle tdo=1 and sd=3'b101; busy=1 during CAP.
2. Capture 3'b101, 3 shifts with tdi=0,1,1, then update_dr -> tdo sequence 1,0,1; sd=3'b110; up_dr pulses once; frame_ok=1.
3. Capture, 2 shifts, update_dr -> up_dr=1 with frame_ok=0. Same with 4 shifts -> frame_ok=0 (cnt saturated).
4. capture_dr, shift_dr and update_dr all high from IDLE -> CAP taken; sr=pad_in; no up_dr that cycle.
5. Shift 1 bit, drop shift_dr for 3 cycles, shift 2 more bits, update -> sr held during the pause; frame_ok=1.
6. rst_l=0 after 2 of 3 shifts -> next cycle sd=0, tdo=0, up_dr=0; a following update_dr gives frame_ok=0.

Source files
------------

// File: rtl/bw_io_bs_pkg.sv
// Shared types and constants for the IO boundary-scan capture/shift segment.
package bw_io_bs_pkg;

    localparam int unsigned BS_SEG_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP   = 2'd1,
        SHIFT = 2'd2,
        UPD   = 2'd3
    } bs_dr_state_e;

    function automatic int unsigned bs_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bw_io_bs_cell.sv
// One boundary-scan capture/shift cell: parallel capture has priority over serial shift.
module bw_io_bs_cell (
    input  logic clk,
    input  logic rst_l,
    input  logic load,
    input  logic shift,
    input  logic pad,
    input  logic si,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            q <= 1'b0;
        end else if (load) begin
            q <= pad;
        end else if (shift) begin
            q <= si;
        end
    end

endmodule

// File: rtl/bw_io_bs_capshift_3x.sv
// Boundary-scan DR capture/shift segment with shift counting and a one-cycle update strobe.
module bw_io_bs_capshift_3x
    import bw_io_bs_pkg::*;
#(
    parameter int unsigned WIDTH = BS_SEG_WIDTH,
    parameter int unsigned CNT_W = bs_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             tdi,
    input  logic [WIDTH-1:0] pad_in,
    output logic             tdo,
    output logic [WIDTH-1:0] sd,
    output logic             up_dr,
    output logic             frame_ok,
    output logic             busy
);

    // The overshift code WIDTH+1 can need one bit beyond CNT_W.
    localparam int unsigned CNT_IW = CNT_W + (((WIDTH + 1) >= (1 << CNT_W)) ? 1 : 0);
    localparam logic [CNT_IW-1:0] CNT_FULL = CNT_IW'(WIDTH);
    localparam logic [CNT_IW-1:0] CNT_SAT  = CNT_IW'(WIDTH + 1);

    bs_dr_state_e      state;
    bs_dr_state_e      state_nxt;
    logic [CNT_IW-1:0] cnt;
    logic [CNT_IW-1:0] cnt_nxt;
    logic [CNT_IW-1:0] cnt_inc_c;
    logic              load_c;
    logic              shift_c;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  si;

    // Serial chain: tdi enters at the MSB cell, tdo leaves from cell 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_msb
            assign si[i] = tdi;
        end else begin : g_lo
            assign si[i] = sr[i+1];
        end

        bw_io_bs_cell u_cell (
            .clk   (clk),
            .rst_l (rst_l),
            .load  (load_c),
            .shift (shift_c),
            .pad   (pad_in[i]),
            .si    (si[i]),
            .q     (sr[i])
        );
    end

    assign tdo = sr[0];
    assign sd  = sr;

    assign cnt_inc_c = (cnt == CNT_SAT) ? cnt : cnt + CNT_IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state    <= IDLE;
            cnt      <= '0;
            up_dr    <= 1'b0;
            frame_ok <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            up_dr    <= (state_nxt == UPD);
            frame_ok <= (state_nxt == UPD) && (cnt_nxt == CNT_FULL);
            busy     <= (state_nxt != IDLE);
        end
    end

    // Request priority everywhere: capture > shift > update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture_dr) begin
                    state_nxt = CAP;
                end else if (shift_dr) begin
                    state_nxt = SHIFT;
                    shift_c   = 1'b1;
                    cnt_nxt   = cnt_inc_c;
                end else if (update_dr) begin
                    state_nxt = UPD;
                end
            end
            CAP: begin
                load_c  = 1'b1;
                cnt_nxt = '0;
                if (shift_dr) begin
                    state_nxt = SHIFT;
                end else if (update_dr) begin
                    state_nxt = UPD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (capture_dr) begin
                    state_nxt = CAP;
                end else if (shift_dr) begin
                    shift_c = 1'b1;
                    cnt_nxt = cnt_inc_c;
                end else if (update_dr) begin
                    state_nxt = UPD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            UPD: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bw_io_bs_capshift_3x.sv
// Scoreboard bench for bw_io_bs_capshift_3x: expected update frames are queued at update_dr and matched on up_dr.
module tb_bw_io_bs_capshift_3x;

    localparam int unsigned W = 3;

    typedef struct packed {
        logic [W-1:0] sd;
        logic         frame_ok;
    } exp_t;

    logic         clk;
    logic         rst_l;
    logic         capture_dr;
    logic         shift_dr;
    logic         update_dr;
    logic         tdi;
    logic [W-1:0] pad_in;
    logic         tdo;
    logic [W-1:0] sd;
    logic         up_dr;
    logic         frame_ok;
    logic         busy;

    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic prev_up;

    bw_io_bs_capshift_3x #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tdi        (tdi),
        .pad_in     (pad_in),
        .tdo        (tdo),
        .sd         (sd),
        .up_dr      (up_dr),
        .frame_ok   (frame_ok),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, return 1ns after the active edge.
    task automatic step(input logic cap, input logic sh, input logic upd, input logic t);
        capture_dr = cap;
        shift_dr   = sh;
        update_dr  = upd;
        tdi        = t;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [W-1:0] p);
        pad_in = p;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [W-1:0] exp_sd, input logic exp_ok);
        exp_t e;
        e.sd       = exp_sd;
        e.frame_ok = exp_ok;
        sb_q.push_back(e);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Output side of the scoreboard: every up_dr pulse consumes one expected frame.
    always @(negedge clk) begin
        if (up_dr) begin
            exp_t e;
            chk("up_dr_single", 32'(prev_up), 32'd0);
            if (sb_q.size() == 0) begin
                chk("up_dr_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("upd_sd", 32'(sd), 32'(e.sd));
                chk("upd_frame_ok", 32'(frame_ok), 32'(e.frame_ok));
            end
        end
        prev_up = up_dr;
    end

    initial begin
        checks     = 0;
        failures   = 0;
        prev_up    = 1'b0;
        rst_l      = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        tdi        = 1'b0;
        pad_in     = '0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_up_dr", 32'(up_dr), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_l = 1'b1;

        // Capture: busy in CAP, data visible the cycle after.
        pad_in = 3'b101;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cap_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("cap_tdo", 32'(tdo), 32'd1);
        chk("cap_sd", 32'(sd), 32'(3'b101));
        chk("cap_idle", 32'(busy), 32'd0);

        // Full frame of three shifts.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sh1_tdo", 32'(tdo), 32'd0);
        chk("sh_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("sh2_tdo", 32'(tdo), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("sh3_sd", 32'(sd), 32'(3'b110));
        update(3'b110, 1'b1);

        // Short frame.
        capture(3'b100);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        update(3'b011, 1'b0);

        // Overshift saturates the counter.
        capture(3'b001);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        update(3'b011, 1'b0);

        // All requests at once: capture wins.
        pad_in = 3'b010;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("prio_no_up", 32'(up_dr), 32'd0);
        chk("prio_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("prio_sd", 32'(sd), 32'(3'b010));
        chk("prio_no_up2", 32'(up_dr), 32'd0);

        // Paused shift holds data and count.
        capture(3'b111);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("pause_sd", 32'(sd), 32'(3'b011));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        update(3'b010, 1'b1);

        // Capture mid-shift restarts the frame.
        capture(3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        capture(3'b110);
        chk("recap_sd", 32'(sd), 32'(3'b110));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        update(3'b000, 1'b1);

        // Update with no shift still strobes.
        update(3'b000, 1'b0);

        // Reset mid-shift discards the frame.
        capture(3'b101);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        rst_l = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("mrst_sd", 32'(sd), 32'd0);
        chk("mrst_tdo", 32'(tdo), 32'd0);
        chk("mrst_up_dr", 32'(up_dr), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        rst_l = 1'b1;
        update(3'b000, 1'b0);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
